// File: rtl/sy_irq_cond.sv
`default_nettype none
// ============================================================================
// Module   : sy_irq_cond
// Purpose  : Per-source interrupt conditioner ahead of the PLIC. Synchronises,
//            optionally glitch-filters (macro SY_IRQ_COND_FILTER_EN) and
//            converts edge sources into a saturating pending count.
// Revision : 1.0 - initial release
// ============================================================================
module sy_irq_cond #(
    parameter int                    SOURCE_NUM    = 30,
    parameter int                    SYNC_STAGES   = 2,
    parameter int                    FILTER_CYCLES = 4,
    parameter logic [SOURCE_NUM-1:0] EDGE_MASK     = '0,
    parameter int                    PEND_MAX      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SOURCE_NUM-1:0] irq_raw_i,
    input  logic [SOURCE_NUM-1:0] irq_done_i,
    output logic [SOURCE_NUM-1:0] irq_sources_o
);

    localparam int                  c_PEND_W   = $clog2(PEND_MAX + 1);
    localparam logic [c_PEND_W-1:0] c_PEND_MAX = c_PEND_W'(PEND_MAX);
    localparam logic [c_PEND_W-1:0] c_PEND_ONE = c_PEND_W'(1);

    // Stage 0 samples the raw lines; stage SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0][SOURCE_NUM-1:0] r_sync;
    logic [SOURCE_NUM-1:0]                  w_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq_raw_i};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifndef SY_IRQ_COND_FILTER_EN
    localparam int c_unused_filter_cycles = FILTER_CYCLES;
`endif

    for (genvar i = 0; i < SOURCE_NUM; i++) begin : g_src
        logic w_filt;
        logic w_rise;

`ifdef SY_IRQ_COND_FILTER_EN
        localparam int                 c_CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
        localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_CYCLES - 1);
        localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

        logic               r_filt;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_update;

        assign w_update = (w_sync[i] != r_filt) && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_filt <= 1'b0;
                r_cnt  <= '0;
            end else if (w_sync[i] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt <= w_sync[i];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end

        assign w_filt = r_filt;
        assign w_rise = w_update & w_sync[i];
`else
        // Without the filter the update event is the last sync stage changing.
        assign w_filt = w_sync[i];
        assign w_rise = r_sync[SYNC_STAGES-2][i] & ~r_sync[SYNC_STAGES-1][i];
`endif

        if (EDGE_MASK[i]) begin : g_edge
            logic [c_PEND_W-1:0] r_pend;
            logic                w_unused_filt;

            assign w_unused_filt = w_filt;

            // A done that coincides with a rise cancels it, except from empty.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_pend <= '0;
                end else begin
                    case ({w_rise, irq_done_i[i]})
                        2'b10: if (r_pend != c_PEND_MAX) r_pend <= r_pend + c_PEND_ONE;
                        2'b01: if (r_pend != '0)         r_pend <= r_pend - c_PEND_ONE;
                        2'b11: if (r_pend == '0)         r_pend <= c_PEND_ONE;
                        default: ;
                    endcase
                end
            end

            assign irq_sources_o[i] = (r_pend != '0);
        end else begin : g_level
            logic w_unused_level;

            assign w_unused_level   = irq_done_i[i] ^ w_rise;
            assign irq_sources_o[i] = w_filt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sy_irq_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_sy_irq_cond
// Purpose  : Directed-vector bench for sy_irq_cond, filter on or off build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sy_irq_cond;

    localparam int N = 30;
    localparam int S = 2;
    localparam int F = 4;
`ifdef SY_IRQ_COND_FILTER_EN
    localparam int L = S + F - 1;
`else
    localparam int L = S - 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] done;
    logic [N-1:0] out;

    always #5 clk = ~clk;

    sy_irq_cond #(
        .SOURCE_NUM    (N),
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F),
        .EDGE_MASK     (30'h4),
        .PEND_MAX      (3)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .irq_raw_i     (raw),
        .irq_done_i    (done),
        .irq_sources_o (out)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] raw;
        logic [2:0] done;
        int         n;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(string nm, logic r, logic [2:0] rw, logic [2:0] d, int n, logic [2:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.raw = rw; v.done = d; v.n = n; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic void add_rep(string nm, logic [2:0] rw, int cnt, logic [2:0] e);
        for (int k = 0; k < cnt; k++) add(nm, 1'b0, rw, 3'b000, 1, e);
    endfunction

    // Drive inputs just after an edge, clock n edges, then compare.
    task automatic chk(string nm, logic r, logic [2:0] rw, logic [2:0] d, int n, logic [2:0] e);
        logic [N-1:0] want;
        rst  = r;
        raw  = {{(N-3){1'b0}}, rw};
        done = {{(N-3){1'b0}}, d};
        repeat (n) @(posedge clk);
        #1;
        want = {{(N-3){1'b0}}, e};
        n_vec++;
        if (out !== want) begin
            n_err++;
            $display("FAIL %s: irq_sources_o=%h expected %h at %0t", nm, out, want, $time);
        end
    endtask

    initial begin
        rst  = 1'b1;
        raw  = '0;
        done = '0;

        add("reset", 1'b1, 3'b000, 3'b000, 2, 3'b000);
        // Level source 0, with done pulses ignored.
        add("lvl0_lat",      1'b0, 3'b001, 3'b000, L, 3'b000);
        add("lvl0_rise",     1'b0, 3'b001, 3'b000, 1, 3'b001);
        add("lvl0_done_ign", 1'b0, 3'b001, 3'b011, 1, 3'b001);
        add("lvl0_hold",     1'b0, 3'b001, 3'b000, 4, 3'b001);
        add("lvl0_fall_lat", 1'b0, 3'b000, 3'b000, L, 3'b001);
        add("lvl0_fall",     1'b0, 3'b000, 3'b000, 1, 3'b000);
        add("idle",          1'b0, 3'b000, 3'b000, 4, 3'b000);
`ifdef SY_IRQ_COND_FILTER_EN
        add_rep("glitch3_hi",  3'b010, 3, 3'b000);
        add_rep("glitch3_lo",  3'b000, 8, 3'b000);
        add_rep("pulse4_hi",   3'b010, 4, 3'b000);
        add_rep("pulse4_wait", 3'b000, 1, 3'b000);
        add_rep("pulse4_out",  3'b000, 4, 3'b010);
        add_rep("pulse4_end",  3'b000, 1, 3'b000);
`else
        add("pulse1_hi",  1'b0, 3'b001, 3'b000, 1, 3'b000);
        add("pulse1_out", 1'b0, 3'b000, 3'b000, 1, 3'b001);
        add("pulse1_end", 1'b0, 3'b000, 3'b000, 1, 3'b000);
`endif
        // Edge source 2: five pulses saturate at three.
        add("edge_lat",   1'b0, 3'b100, 3'b000, L, 3'b000);
        add("edge_rise",  1'b0, 3'b100, 3'b000, 1, 3'b100);
        add("edge_p1_hi", 1'b0, 3'b100, 3'b000, 6 - L - 1, 3'b100);
        add("edge_p1_lo", 1'b0, 3'b000, 3'b000, 6, 3'b100);
        for (int p = 2; p <= 5; p++) begin
            add($sformatf("edge_p%0d_hi", p), 1'b0, 3'b100, 3'b000, 6, 3'b100);
            add($sformatf("edge_p%0d_lo", p), 1'b0, 3'b000, 3'b000, 6, 3'b100);
        end
        add("done1", 1'b0, 3'b000, 3'b100, 1, 3'b100);
        add("done2", 1'b0, 3'b000, 3'b100, 1, 3'b100);
        add("done3", 1'b0, 3'b000, 3'b100, 1, 3'b000);
        add("done4", 1'b0, 3'b000, 3'b100, 1, 3'b000);
        add("post_lat",  1'b0, 3'b100, 3'b000, L, 3'b000);
        add("post_rise", 1'b0, 3'b100, 3'b000, 1, 3'b100);
        add("post_lo",   1'b0, 3'b000, 3'b000, 6, 3'b100);
        add("post_done", 1'b0, 3'b000, 3'b100, 1, 3'b000);
        add("post_idle", 1'b0, 3'b000, 3'b000, 6, 3'b000);

        for (int k = 0; k < tbl.size(); k++)
            chk(tbl[k].name, tbl[k].rst, tbl[k].raw, tbl[k].done, tbl[k].n, tbl[k].exp);

        // Rise and done in the same cycle with pend=2.
        chk("sc_a_hi", 1'b0, 3'b100, 3'b000, 6, 3'b100);
        chk("sc_a_lo", 1'b0, 3'b000, 3'b000, 6, 3'b100);
        chk("sc_b_hi", 1'b0, 3'b100, 3'b000, 6, 3'b100);
        chk("sc_b_lo", 1'b0, 3'b000, 3'b000, 6, 3'b100);
        chk("sc2_lat",  1'b0, 3'b100, 3'b000, L, 3'b100);
        chk("sc2_both", 1'b0, 3'b100, 3'b100, 1, 3'b100);
        chk("sc2_d1",   1'b0, 3'b000, 3'b100, 1, 3'b100);
        chk("sc2_d2",   1'b0, 3'b000, 3'b100, 1, 3'b000);
        chk("sc_settle", 1'b0, 3'b000, 3'b000, 8, 3'b000);

        // Rise and done in the same cycle with pend=0.
        chk("sc0_lat",  1'b0, 3'b100, 3'b000, L, 3'b000);
        chk("sc0_both", 1'b0, 3'b100, 3'b100, 1, 3'b100);
        chk("sc0_hold", 1'b0, 3'b100, 3'b000, 2, 3'b100);
        chk("sc0_lo",   1'b0, 3'b000, 3'b000, 6, 3'b100);
        chk("sc0_done", 1'b0, 3'b000, 3'b100, 1, 3'b000);
        chk("sc0_idle", 1'b0, 3'b000, 3'b000, 6, 3'b000);

        // Reset mid-operation with pend[2]=2 and source 0 high.
        chk("rst_a_hi",  1'b0, 3'b100, 3'b000, 6, 3'b100);
        chk("rst_a_lo",  1'b0, 3'b000, 3'b000, 6, 3'b100);
        chk("rst_b_hi",  1'b0, 3'b100, 3'b000, 6, 3'b100);
        chk("rst_b_lo",  1'b0, 3'b000, 3'b000, 6, 3'b100);
        chk("rst_pre",   1'b0, 3'b001, 3'b000, L + 1, 3'b101);
        chk("rst_apply", 1'b1, 3'b001, 3'b000, 1, 3'b000);
        chk("rst_requal_lat", 1'b0, 3'b001, 3'b000, L, 3'b000);
        chk("rst_requal",     1'b0, 3'b001, 3'b000, 1, 3'b001);
        chk("rst_no_replay",  1'b0, 3'b001, 3'b000, 6, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
